// File: rtl/alu_pkg.sv
// Shared types for the datapath ALU: operation select and NZCV flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_ORR = 4'd3,
        ALU_EOR = 4'd4
    } alu_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu.sv
// 32-bit integer ALU with ARM-style NZCV flags; combinational result plus a
// registered copy for flag/forwarding logic one cycle later.
module alu
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  alu_op_t     alu_opcode,
    input  logic [31:0] data_in1,
    input  logic [31:0] data_in2,
    output logic [31:0] data_out,
    output alu_flags_t  flags_out,
    output logic [31:0] data_out_q,
    output alu_flags_t  flags_out_q
);

    logic [32:0] sum;
    logic [31:0] result;
    logic        carry;
    logic        ovf;

    always_comb begin
        sum    = '0;
        result = '1;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_opcode)
            ALU_ADD: begin
                sum    = {1'b0, data_in1} + {1'b0, data_in2};
                result = sum[31:0];
                carry  = sum[32];
                ovf    = (data_in1[31] == data_in2[31]) && (result[31] != data_in1[31]);
            end
            ALU_SUB: begin
                // A + ~B + 1: carry out of bit 32 is the inverted borrow
                sum    = {1'b0, data_in1} + {1'b0, ~data_in2} + 33'd1;
                result = sum[31:0];
                carry  = sum[32];
                ovf    = (data_in1[31] != data_in2[31]) && (result[31] != data_in1[31]);
            end
            ALU_AND: result = data_in1 & data_in2;
            ALU_ORR: result = data_in1 | data_in2;
            ALU_EOR: result = data_in1 ^ data_in2;
            default: result = '1;
        endcase
    end

    assign data_out    = result;
    assign flags_out.n = result[31];
    assign flags_out.z = (result == '0);
    assign flags_out.c = carry;
    assign flags_out.v = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q  <= '0;
            flags_out_q <= '0;
        end else begin
            data_out_q  <= data_out;
            flags_out_q <= flags_out;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed flag corners, register behaviour, and random
// vectors checked against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    alu_op_t     alu_opcode;
    logic [31:0] data_in1;
    logic [31:0] data_in2;
    logic [31:0] data_out;
    alu_flags_t  flags_out;
    logic [31:0] data_out_q;
    alu_flags_t  flags_out_q;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .alu_opcode (alu_opcode),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_out   (data_out),
        .flags_out  (flags_out),
        .data_out_q (data_out_q),
        .flags_out_q(flags_out_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Returns {N,Z,C,V,result}, derived from integer arithmetic on wide values.
    function automatic logic [35:0] ref_alu(input int unsigned op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r  = 0;
        longint s  = 0;
        logic   c  = 1'b0;
        logic   v  = 1'b0;
        logic [31:0] res;
        case (op)
            0: begin
                r = ua + ub; s = sa + sb;
                c = (r > 64'sd4294967295);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                r = ua - ub; s = sa - sb;
                c = (ua >= ub);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: r = longint'({32'd0, a & b});
            3: r = longint'({32'd0, a | b});
            4: r = longint'({32'd0, a ^ b});
            default: r = 64'sd4294967295;
        endcase
        res = r[31:0];
        return {res[31], res == 32'd0, c, v, res};
    endfunction

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_opcode = alu_op_t'(op);
        data_in1   = a;
        data_in2   = b;
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    vec_t dir[14] = '{
        '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110},
        '{4'd0, 32'h80000000, 32'h80000000, 32'h00000000, 4'b0111},
        '{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001},
        '{4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1010},
        '{4'd1, 32'h00000010, 32'h00000005, 32'h0000000B, 4'b0010},
        '{4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110},
        '{4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000},
        '{4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011},
        '{4'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 4'b1001},
        '{4'd2, 32'hAAAAAAAA, 32'h55555555, 32'h00000000, 4'b0100},
        '{4'd2, 32'h12345678, 32'hFF00FF00, 32'h12005600, 4'b0000},
        '{4'd3, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 4'b1000},
        '{4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100},
        '{4'd7, 32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF, 4'b1000}
    };

    initial begin
        logic [35:0] exp;
        logic [35:0] prev;

        rst = 1'b1;
        alu_opcode = ALU_ADD;
        data_in1 = 32'h0;
        data_in2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_q",  data_out_q, 32'h0);
        check("rst_flags_q", {28'd0, flags_out_q}, 32'h0);

        foreach (dir[i]) begin
            apply(dir[i].op, dir[i].a, dir[i].b);
            check($sformatf("dir%0d_data", i),  data_out, dir[i].r);
            check($sformatf("dir%0d_flags", i), {28'd0, flags_out}, {28'd0, dir[i].f});
        end

        apply(4'd0, 32'h1234, 32'h5678);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reg_data_q",  data_out_q, 32'h000068AC);
        check("reg_flags_q", {28'd0, flags_out_q}, 32'h0);

        apply(4'd1, 32'h0, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_data_q",  data_out_q, 32'h0);
        check("midrst_flags_q", {28'd0, flags_out_q}, 32'h0);
        check("midrst_comb",    data_out, 32'hFFFFFFFF);
        check("midrst_flags",   {28'd0, flags_out}, 32'h8);
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            logic [3:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 4'($urandom_range(0, 4));
            a  = $urandom();
            b  = $urandom();
            if (i % 8 == 0) b = a;
            if (i % 16 == 1) a = 32'h80000000;
            apply(op, a, b);
            exp = ref_alu(int'(op), a, b);
            check("rnd_data",  data_out, exp[31:0]);
            check("rnd_flags", {28'd0, flags_out}, {28'd0, exp[35:32]});
            prev = exp;
            @(posedge clk); #1;
            check("rnd_data_q",  data_out_q, prev[31:0]);
            check("rnd_flags_q", {28'd0, flags_out_q}, {28'd0, prev[35:32]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
